// File: rtl/tea_operand_loader_if.sv
// Operand-set handshake between the TEA operand loader (master) and the cipher core (slave).
interface tea_operand_loader_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] v0;
   logic [31:0] v1;
   logic [31:0] k0;
   logic [31:0] k1;
   logic [31:0] k2;
   logic [31:0] k3;

   modport master (output out_valid, v0, v1, k0, k1, k2, k3, input out_ready);
   modport slave  (input out_valid, v0, v1, k0, k1, k2, k3, output out_ready);
endinterface

// File: rtl/tea_operand_loader.sv
// Byte-at-a-time TEA operand entry from switches and debounced buttons, handed to the cipher via valid/ready.
// Optional macro TEA_LOADER_BACKSPACE_EN turns the clear button into a byte/word backspace.
module tea_operand_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [7:0]            sw,
   input  logic                  load_btn,
   input  logic                  clear_btn,
   tea_operand_loader_if.master  bus,
   output logic [2:0]            word_idx,
   output logic [1:0]            byte_idx,
   output logic [31:0]           preview
);

   localparam int unsigned NBTN      = 2;
   localparam int unsigned NWORDS    = 6;
   localparam int unsigned LAST_WORD = 5;

   typedef enum logic {COLLECT = 1'b0, PRESENT = 1'b1} state_e;

   logic [NBTN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NBTN-1:0]  stable_q, stable_d, press_q, press_d;
   logic [CNT_W-1:0] cnt_q [NBTN];
   logic [CNT_W-1:0] cnt_d [NBTN];

   state_e      state_q, state_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [2:0]  word_idx_q, word_idx_d;
   logic [31:0] words_q [NWORDS];
   logic [31:0] words_d [NWORDS];
   logic        out_valid_q, out_valid_d;

   logic load_press, clear_press;

   // Two-flop synchroniser and per-button debounce; bit 0 = load, bit 1 = clear
   always_comb begin
      sync1_d  = {clear_btn, load_btn};
      sync2_d  = sync1_q;
      stable_d = stable_q;
      for (int i = 0; i < int'(NBTN); i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               stable_d[i] = ~stable_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      press_d = stable_d & ~stable_q;
   end

   assign load_press  = press_q[0];
   assign clear_press = press_q[1];

`ifdef TEA_LOADER_BACKSPACE_EN
   logic [31:0] prev_word;

   always_comb begin
      prev_word = '0;
      for (int i = 0; i < int'(NWORDS) - 1; i++) begin
         if (word_idx_q == 3'(i + 1)) prev_word = words_q[i];
      end
   end
`endif

   // Entry / presentation FSM; clear takes priority over a coincident load
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      byte_idx_d  = byte_idx_q;
      word_idx_d  = word_idx_q;
      out_valid_d = out_valid_q;
      for (int i = 0; i < int'(NWORDS); i++) words_d[i] = words_q[i];

      unique case (state_q)
         COLLECT: begin
            if (clear_press) begin
`ifdef TEA_LOADER_BACKSPACE_EN
               if (byte_idx_q != 2'd0) begin
                  shift_d    = shift_q >> 8;
                  byte_idx_d = byte_idx_q - 2'd1;
               end else if (word_idx_q != 3'd0) begin
                  word_idx_d = word_idx_q - 3'd1;
                  shift_d    = {8'h00, prev_word[31:8]};
                  byte_idx_d = 2'd3;
               end
`else
               shift_d    = '0;
               byte_idx_d = 2'd0;
`endif
            end else if (load_press) begin
               if (byte_idx_q == 2'd3) begin
                  for (int i = 0; i < int'(NWORDS); i++) begin
                     if (word_idx_q == 3'(i)) words_d[i] = {shift_q[23:0], sw};
                  end
                  shift_d    = '0;
                  byte_idx_d = 2'd0;
                  if (word_idx_q == 3'(LAST_WORD)) begin
                     state_d     = PRESENT;
                     out_valid_d = 1'b1;
                  end else begin
                     word_idx_d = word_idx_q + 3'd1;
                  end
               end else begin
                  shift_d    = {shift_q[23:0], sw};
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end
         end
         PRESENT: begin
            if (bus.out_ready) begin
               state_d     = COLLECT;
               out_valid_d = 1'b0;
               word_idx_d  = 3'd0;
               byte_idx_d  = 2'd0;
               shift_d     = '0;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         stable_q    <= '0;
         press_q     <= '0;
         for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= '0;
         state_q     <= COLLECT;
         shift_q     <= '0;
         byte_idx_q  <= '0;
         word_idx_q  <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < int'(NWORDS); i++) words_q[i] <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         stable_q    <= stable_d;
         press_q     <= press_d;
         for (int i = 0; i < int'(NBTN); i++) cnt_q[i] <= cnt_d[i];
         state_q     <= state_d;
         shift_q     <= shift_d;
         byte_idx_q  <= byte_idx_d;
         word_idx_q  <= word_idx_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < int'(NWORDS); i++) words_q[i] <= words_d[i];
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.v0        = words_q[0];
   assign bus.v1        = words_q[1];
   assign bus.k0        = words_q[2];
   assign bus.k1        = words_q[3];
   assign bus.k2        = words_q[4];
   assign bus.k3        = words_q[5];
   assign word_idx      = word_idx_q;
   assign byte_idx      = byte_idx_q;
   assign preview       = shift_q;

endmodule

// File: tb/tb_tea_operand_loader.sv
// Bench for tea_operand_loader: byte-list reference model, scoreboard of completed operand sets, randomized entry.
module tb_tea_operand_loader;

   localparam int unsigned DEB  = 4;
   localparam int unsigned HOLD = 12;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  sw;
   logic        load_btn;
   logic        clear_btn;
   logic [2:0]  word_idx;
   logic [1:0]  byte_idx;
   logic [31:0] preview;

   tea_operand_loader_if bus ();

   tea_operand_loader #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .sw        (sw),
      .load_btn  (load_btn),
      .clear_btn (clear_btn),
      .bus       (bus),
      .word_idx  (word_idx),
      .byte_idx  (byte_idx),
      .preview   (preview)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the current word is a list of entered bytes, MSB first
   logic [7:0]   m_bytes [$];
   logic [31:0]  m_words [6];
   int           m_w;
   bit           m_present;
   logic [191:0] exp_q [$];

   task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] m_preview();
      logic [31:0] acc = '0;
      foreach (m_bytes[i]) acc = (acc << 8) | 32'(m_bytes[i]);
      return acc;
   endfunction

   function automatic logic [191:0] m_set();
      return {m_words[0], m_words[1], m_words[2], m_words[3], m_words[4], m_words[5]};
   endfunction

   function automatic void model_reset();
      m_bytes.delete();
      foreach (m_words[i]) m_words[i] = '0;
      m_w = 0;
      m_present = 1'b0;
   endfunction

   function automatic void model_load(input logic [7:0] b);
      if (m_present) return;
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
         m_words[m_w] = m_preview();
         m_bytes.delete();
         if (m_w == 5) begin
            m_present = 1'b1;
            exp_q.push_back(m_set());
         end else begin
            m_w++;
         end
      end
   endfunction

   function automatic void model_clear();
      if (m_present) return;
`ifdef TEA_LOADER_BACKSPACE_EN
      if (m_bytes.size() > 0) begin
         void'(m_bytes.pop_back());
      end else if (m_w > 0) begin
         m_w--;
         m_bytes.push_back(m_words[m_w][31:24]);
         m_bytes.push_back(m_words[m_w][23:16]);
         m_bytes.push_back(m_words[m_w][15:8]);
      end
`else
      m_bytes.delete();
`endif
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clean press and release; the model is updated once the press has settled
   task automatic press(input bit l, input bit c, input logic [7:0] b);
      sw        = b;
      load_btn  = l;
      clear_btn = c;
      tick(HOLD);
      load_btn  = 1'b0;
      clear_btn = 1'b0;
      tick(HOLD);
      if (c) model_clear();
      else if (l) model_load(b);
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      chk({tag, ".word_idx"},  192'(word_idx),      192'(m_w));
      chk({tag, ".byte_idx"},  192'(byte_idx),      192'(m_bytes.size()));
      chk({tag, ".preview"},   192'(preview),       192'(m_preview()));
      chk({tag, ".out_valid"}, 192'(bus.out_valid), 192'(m_present));
      chk({tag, ".words"},     {bus.v0, bus.v1, bus.k0, bus.k1, bus.k2, bus.k3}, m_set());
      tick(1);
   endtask

   task automatic handshake();
      tick($urandom_range(0, 5));
      bus.out_ready = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
      m_present = 1'b0;
      m_w = 0;
      m_bytes.delete();
   endtask

   // Scoreboard monitor: every transfer must match the oldest completed set
   initial begin
      forever begin
         @(negedge clk);
         if (resetn && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("xfer_unexpected", 192'(1), 192'(0));
            end else begin
               chk("xfer_set", {bus.v0, bus.v1, bus.k0, bus.k1, bus.k2, bus.k3}, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int drops;
      int iters;
      int r;
      resetn        = 1'b0;
      sw            = '0;
      load_btn      = 1'b0;
      clear_btn     = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      tick(3);
      resetn = 1'b1;
      check_state("reset");

      for (int i = 1; i <= 24; i++) begin
         press(1'b1, 1'b0, 8'(i));
         if (i % 4 == 3 || i == 24) check_state("seq");
      end
      chk("seq.v0", 192'(bus.v0), 192'(32'h01020304));
      chk("seq.k2", 192'(bus.k2), 192'(32'h11121314));
      chk("seq.k3", 192'(bus.k3), 192'(32'h15161718));

      bus.out_ready = 1'b1;
      bus.out_ready = 1'b0;
      drops = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1) drops++;
      end
      tick(1);
      chk("present.hold_drops", 192'(drops), 192'(0));
      press(1'b1, 1'b0, 8'h77);
      press(1'b0, 1'b1, 8'h00);
      check_state("present.ignore");

      handshake();
      check_state("handshake");
      chk("handshake.v0_kept", 192'(bus.v0), 192'(32'h01020304));

      // Bouncy load: 3-cycle pulses never settle, the final hold registers one press
      sw = 8'h5A;
      for (int i = 0; i < 40; i++) begin
         load_btn = ((i / 3) % 2 == 0);
         tick(1);
      end
      load_btn = 1'b1;
      tick(10);
      load_btn = 1'b0;
      tick(HOLD);
      model_load(8'h5A);
      check_state("bounce");
      press(1'b0, 1'b1, 8'h00);
      check_state("bounce_clear");

      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      model_reset();
      press(1'b1, 1'b0, 8'hAA);
      press(1'b1, 1'b0, 8'hBB);
      press(1'b0, 1'b1, 8'h00);
      press(1'b1, 1'b0, 8'h11);
      press(1'b1, 1'b0, 8'h22);
      press(1'b1, 1'b0, 8'h33);
      press(1'b1, 1'b0, 8'h44);
      check_state("clear");
`ifndef TEA_LOADER_BACKSPACE_EN
      chk("clear.v0", 192'(bus.v0), 192'(32'h11223344));
      chk("clear.word_idx", 192'(word_idx), 192'(1));
`endif
      press(1'b1, 1'b0, 8'h55);
      press(1'b1, 1'b1, 8'h66);
      check_state("load_clear");

      press(1'b1, 1'b0, 8'hC1);
      press(1'b1, 1'b0, 8'hC2);
      resetn = 1'b0;
      tick(1);
      model_reset();
      check_state("reset_mid");
      resetn = 1'b1;
      tick(1);

      // Randomized rounds through to a completed, transferred operand set
      for (int round = 0; round < 2; round++) begin
         iters = 0;
         while (!m_present && iters < 200) begin
            r = $urandom_range(0, 19);
            if (r < 17)       press(1'b1, 1'b0, 8'($urandom));
            else if (r < 19)  press(1'b0, 1'b1, 8'h00);
            else              press(1'b1, 1'b1, 8'($urandom));
            if (r >= 17 || (iters % 5) == 0) check_state("rand");
            iters++;
         end
         chk("rand.completed", 192'(m_present), 192'(1));
         check_state("rand.present");
         handshake();
         check_state("rand.xfer");
      end

`ifdef TEA_LOADER_BACKSPACE_EN
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      model_reset();
      for (int i = 1; i <= 4; i++) press(1'b1, 1'b0, 8'(i));
      press(1'b0, 1'b1, 8'h00);
      check_state("bksp");
      chk("bksp.preview", 192'(preview), 192'(32'h00010203));
      chk("bksp.byte_idx", 192'(byte_idx), 192'(3));
      press(1'b1, 1'b0, 8'h99);
      chk("bksp.v0", 192'(bus.v0), 192'(32'h01020399));
      check_state("bksp.reenter");
`endif

      tick(2);
      chk("scoreboard_empty", 192'(exp_q.size()), 192'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
